// File: rtl/amber48_pkg.sv
// amber48_pkg: shared enums and helpers for the amber48 status LED controller
package amber48_pkg;
  typedef enum logic [1:0] {
    LED_MODE_MMIO,
    LED_MODE_STATUS,
    LED_MODE_MMIO_TRAP,
    LED_MODE_TRAP_ALL
  } led_mode_e;
  typedef enum logic [1:0] {
    BLINK_IDLE,
    BLINK_ON,
    BLINK_OFF,
    BLINK_GAP
  } blink_state_e;
  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/amber48_pulse_stretch.sv
// amber48_pulse_stretch: retriggerable activity stretcher holding act_o for CYC cycles after the last event
module amber48_pulse_stretch #(
  parameter int CYC = 2700000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic event_i,
  output logic act_o
);
  localparam int W = $clog2(CYC + 1);
  logic [W-1:0] r_cnt;
  // reload on every event, otherwise count down to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_cnt <= '0;
    else if (event_i) r_cnt <= W'(CYC);
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign act_o = (r_cnt != '0);
endmodule

// File: rtl/amber48_status_led.sv
// amber48_status_led: heartbeat, activity stretch, trap latch and blink-code LED controller
module amber48_status_led
  import amber48_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int NUM_CH      = 4,
  parameter int CAUSE_W     = 3,
  parameter int HB_DIV      = 13500000,
  parameter int STRETCH_CYC = 2700000,
  parameter int BLINK_CYC   = 5400000,
  parameter int GAP_CYC     = 27000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_CH-1:0]   event_i,
  input  logic                trap_i,
  input  logic [CAUSE_W-1:0]  trap_cause_i,
  input  logic                clear_i,
  input  logic [1:0]          mode_i,
  input  logic [NUM_LEDS-1:0] mmio_led_i,
  output logic [NUM_LEDS-1:0] led_o,
  output logic                trapped_o,
  output logic [CAUSE_W-1:0]  trap_cause_o
);
  localparam int HB_W = $clog2(HB_DIV);
  localparam int PH_W = $clog2(max2(BLINK_CYC, GAP_CYC) + 1);
  localparam int P_W  = CAUSE_W + 1;
  localparam logic [HB_W-1:0] HB_LAST  = HB_W'(HB_DIV - 1);
  localparam logic [PH_W-1:0] BL_LAST  = PH_W'(BLINK_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYC - 1);

  if (NUM_LEDS < NUM_CH + 2) begin : g_chk_leds
    $error("amber48_status_led: NUM_LEDS must be >= NUM_CH+2");
  end
  if (HB_DIV < 2) begin : g_chk_hb
    $error("amber48_status_led: HB_DIV must be >= 2");
  end

  logic [HB_W-1:0]     r_hb_cnt;
  logic                r_hb;
  logic [NUM_CH-1:0]   w_act;
  logic                r_trapped;
  logic [CAUSE_W-1:0]  r_cause;
  blink_state_e        r_state, w_state_nxt;
  logic [PH_W-1:0]     r_phase, w_phase_nxt;
  logic [P_W-1:0]      r_p, w_p_nxt, w_p_inc, w_p_last;
  logic                w_bl_end;
  logic                w_blink;
  led_mode_e           w_mode;
  logic [NUM_LEDS-1:0] w_status, w_led_nxt, r_led;

  // free-running heartbeat divider, toggles hb once per HB_DIV cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_hb_cnt == HB_LAST) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_cnt <= r_hb_cnt + HB_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_act
    amber48_pulse_stretch #(.CYC(STRETCH_CYC)) u_stretch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .event_i(event_i[k]),
      .act_o  (w_act[k])
    );
  end

  // sticky trap latch keeps the first cause; clear wins over a same-cycle trap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trapped <= 1'b0;
      r_cause   <= '0;
    end else if (clear_i) begin
      r_trapped <= 1'b0;
      r_cause   <= '0;
    end else if (trap_i && !r_trapped) begin
      r_trapped <= 1'b1;
      r_cause   <= trap_cause_i;
    end
  end

  // blink FSM state, phase counter and pulse count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= BLINK_IDLE;
      r_phase <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_p     <= w_p_nxt;
    end
  end

  // blink FSM next state: cause c emits c+1 ON/OFF pulses then a dark gap
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PH_W'(1);
    w_p_nxt     = r_p;
    w_p_inc     = r_p + P_W'(1);
    w_p_last    = {1'b0, r_cause} + P_W'(1);
    w_bl_end    = (r_phase == BL_LAST);
    if (clear_i) begin
      w_state_nxt = BLINK_IDLE;
      w_phase_nxt = '0;
      w_p_nxt     = '0;
    end else begin
      unique case (r_state)
        BLINK_IDLE: begin
          w_phase_nxt = '0;
          if (r_trapped) begin
            w_state_nxt = BLINK_ON;
            w_p_nxt     = '0;
          end
        end
        BLINK_ON: begin
          if (w_bl_end) begin
            w_state_nxt = BLINK_OFF;
            w_phase_nxt = '0;
          end
        end
        BLINK_OFF: begin
          if (w_bl_end) begin
            w_state_nxt = (w_p_inc == w_p_last) ? BLINK_GAP : BLINK_ON;
            w_phase_nxt = '0;
            w_p_nxt     = w_p_inc;
          end
        end
        BLINK_GAP: begin
          if (r_phase == GAP_LAST) begin
            w_state_nxt = BLINK_ON;
            w_phase_nxt = '0;
            w_p_nxt     = '0;
          end
        end
      endcase
    end
  end

  assign w_blink = (r_state == BLINK_ON);
  assign w_mode  = led_mode_e'(mode_i);

  // LED source select; the result is registered below
  always_comb begin
    w_status               = '0;
    w_status[0]            = r_hb;
    w_status[NUM_CH:1]     = w_act;
    w_status[NUM_LEDS-1]   = w_blink;
    w_led_nxt = (w_mode == LED_MODE_MMIO)      ? mmio_led_i :
                (w_mode == LED_MODE_STATUS)    ? w_status :
                (w_mode == LED_MODE_MMIO_TRAP) ? (r_trapped ? {w_blink, mmio_led_i[NUM_LEDS-2:0]} : mmio_led_i) :
                                                 {NUM_LEDS{w_blink}};
  end

  // registered LED drive
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_led <= '0;
    else r_led <= w_led_nxt;
  end

  assign led_o        = r_led;
  assign trapped_o    = r_trapped;
  assign trap_cause_o = r_cause;
endmodule

// File: tb/tb_amber48_status_led.sv
// tb_amber48_status_led: directed scoreboard bench for amber48_status_led
module tb_amber48_status_led;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] event_i = '0;
  logic       trap_i = 1'b0;
  logic [2:0] trap_cause_i = '0;
  logic       clear_i = 1'b0;
  logic [1:0] mode_i = 2'd1;
  logic [7:0] mmio_led_i = '0;
  logic [7:0] led_o;
  logic       trapped_o;
  logic [2:0] trap_cause_o;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;

  amber48_status_led #(
    .NUM_LEDS(8), .NUM_CH(4), .CAUSE_W(3), .HB_DIV(4),
    .STRETCH_CYC(5), .BLINK_CYC(2), .GAP_CYC(6)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .event_i     (event_i),
    .trap_i      (trap_i),
    .trap_cause_i(trap_cause_i),
    .clear_i     (clear_i),
    .mode_i      (mode_i),
    .mmio_led_i  (mmio_led_i),
    .led_o       (led_o),
    .trapped_o   (trapped_o),
    .trap_cause_o(trap_cause_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [7:0] val, input logic [7:0] mask);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.val  = val;
    e.mask = mask;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = (e.sel == 0) ? (led_o & e.mask) : (e.sel == 1) ? {7'b0, trapped_o} : {5'b0, trap_cause_o};
      checks++;
      assert (obs === e.val)
      else begin
        fails++;
        $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    logic [7:0] v;
    int j;
    @(posedge clk);
    @(posedge clk);
    #1;
    push("rst_led", 0, 8'h00, 8'hFF);
    push("rst_trapped", 1, 8'h00, 8'hFF);
    push("rst_cause", 2, 8'h00, 8'hFF);
    drain();
    rst_i = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      v = (((n - 1) / 4) % 2 == 1) ? 8'h01 : 8'h00;
      push("hb", 0, v, 8'hFF);
      tick();
    end
    event_i = 4'b0001;
    push("stretch1_pre", 0, 8'h00, 8'h02);
    tick();
    event_i = '0;
    for (int i = 1; i <= 5; i++) begin
      push("stretch1_on", 0, 8'h02, 8'h02);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      push("stretch1_off", 0, 8'h00, 8'h02);
      tick();
    end
    event_i = 4'b0100;
    push("stretch2_pre", 0, 8'h00, 8'h08);
    tick();
    event_i = '0;
    for (int i = 1; i <= 3; i++) begin
      push("stretch2_on", 0, 8'h08, 8'h08);
      tick();
    end
    event_i = 4'b0100;
    push("stretch2_retrig", 0, 8'h08, 8'h08);
    tick();
    event_i = '0;
    for (int i = 5; i <= 9; i++) begin
      push("stretch2_hold", 0, 8'h08, 8'h08);
      tick();
    end
    push("stretch2_off", 0, 8'h00, 8'h08);
    tick();
    mode_i = 2'd3;
    trap_i = 1'b1;
    trap_cause_i = 3'd2;
    push("blink_c2", 0, 8'h00, 8'hFF);
    tick();
    trap_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      j = k - 2;
      v = (k >= 2 && (j % 18) < 12 && ((j % 18) % 4) < 2) ? 8'hFF : 8'h00;
      push("blink_c2", 0, v, 8'hFF);
      tick();
    end
    push("blink_trapped", 1, 8'h01, 8'hFF);
    push("blink_cause", 2, 8'h02, 8'hFF);
    drain();
    clear_i = 1'b1;
    push("clear", 1, 8'h00, 8'hFF);
    tick();
    clear_i = 1'b0;
    trap_i = 1'b1;
    trap_cause_i = 3'd1;
    push("sticky_first", 1, 8'h01, 8'hFF);
    push("sticky_first_cause", 2, 8'h01, 8'hFF);
    tick();
    trap_cause_i = 3'd5;
    push("sticky_second", 1, 8'h01, 8'hFF);
    push("sticky_keep_cause", 2, 8'h01, 8'hFF);
    tick();
    clear_i = 1'b1;
    trap_cause_i = 3'd3;
    push("clear_prio", 1, 8'h00, 8'hFF);
    tick();
    clear_i = 1'b0;
    trap_cause_i = 3'd6;
    push("retrap", 1, 8'h01, 8'hFF);
    push("retrap_cause", 2, 8'h06, 8'hFF);
    tick();
    trap_i = 1'b0;
    clear_i = 1'b1;
    mode_i = 2'd2;
    mmio_led_i = 8'h5A;
    tick();
    clear_i = 1'b0;
    trap_i = 1'b1;
    trap_cause_i = 3'd0;
    push("mode2", 0, 8'h5A, 8'hFF);
    tick();
    trap_i = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      v = (k >= 2 && ((k - 2) % 10) < 2) ? 8'hDA : 8'h5A;
      push("mode2_blink", 0, v, 8'hFF);
      tick();
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("mode2_cleared", 0, 8'h5A, 8'hFF);
      tick();
    end
    mmio_led_i = 8'hA5;
    push("mode2_untrapped", 0, 8'hA5, 8'hFF);
    tick();
    mode_i = 2'd0;
    mmio_led_i = 8'h3C;
    push("mode0", 0, 8'h3C, 8'hFF);
    tick();
    mode_i = 2'd3;
    trap_i = 1'b1;
    trap_cause_i = 3'd3;
    push("pre_rst", 0, 8'h00, 8'hFF);
    tick();
    trap_i = 1'b0;
    push("pre_rst", 0, 8'h00, 8'hFF);
    tick();
    push("pre_rst_on", 0, 8'hFF, 8'hFF);
    tick();
    rst_i = 1'b1;
    #2;
    push("async_rst_led", 0, 8'h00, 8'hFF);
    push("async_rst_trapped", 1, 8'h00, 8'hFF);
    push("async_rst_cause", 2, 8'h00, 8'hFF);
    drain();
    push("in_rst", 0, 8'h00, 8'hFF);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("post_rst_idle", 0, 8'h00, 8'hFF);
      push("post_rst_trapped", 1, 8'h00, 8'hFF);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
